group_tx: RTL
=============

Name: group_tx

Overview:
- Transmit end of the group stream protocol: emits GROUP_SIZE-item groups on a data/valid/avail interface, the one consumed by downstream alignment/processing stages.
- Takes wide words (WORD_GROUPS groups each) from an upstream ready/valid source, e.g. a memory read channel, and serializes them group by group.
- When configured, runs num_iters iterations of num_groups_per_iter groups each. Every iteration starts at group 0 of a fresh word.

Parameters:
GROUP_SIZE, 4, items per group
DATA_WIDTH, 8, bits per item
WORD_GROUPS, 4, groups per input word (power of two, >=2)
LOG_WORD_GROUPS, 2, log2(WORD_GROUPS)
LOG_MAX_ITERS, 16, width of iteration counter
LOG_MAX_GROUPS_PER_ITER, 16, width of groups-per-iteration counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
configure  in  1  start/restart pulse
num_iters  in  LOG_MAX_ITERS  iterations to run
num_groups_per_iter  in  LOG_MAX_GROUPS_PER_ITER  groups emitted per iteration
word_in  in  WORD_GROUPS*GROUP_SIZE*DATA_WIDTH  upstream word; group k = bits [(k+1)*G-1 : k*G], G=GROUP_SIZE*DATA_WIDTH
word_valid_in  in  1  upstream word valid
word_ready_out  out  1  upstream ready (word accepted when valid & ready)
data_out  out  GROUP_SIZE*DATA_WIDTH  group data (registered)
valid_out  out  1  group write strobe (registered, one group per high cycle)
avail_in  in  1  downstream can accept a group
done_out  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (rst=0 at posedge): state IDLE; valid_out=0, data_out=0, done_out=0, all counters 0. word_ready_out=0 follows from IDLE. Reset mid-run drops the held word; no further valid_out.
- States:
  - IDLE: wait for configure.
  - FETCH: word_ready_out=1 (decoded from state only, no combinational path from inputs).
  - SEND: serialize the held word.
- configure=1 at a posedge, any state, highest priority:
  - Load iter_cnt=num_iters, grp_cnt=num_groups_per_iter, copy of num_groups_per_iter; grp_idx=0; state FETCH; valid_out=0 next cycle; any held word discarded.
  - If num_iters==0 or num_groups_per_iter==0: state IDLE and done_out=1 next cycle instead.
- FETCH: on word_valid_in & word_ready_out, latch word_in into word_r, grp_idx=0, go SEND.
- SEND, posedge with avail_in=1 (emit):
  - data_out<=word_r group grp_idx, valid_out<=1, then:
  - grp_cnt==1 and iter_cnt==1: state IDLE, done_out<=1 (same cycle as last valid_out).
  - grp_cnt==1, iter_cnt>1: iter_cnt-1, grp_cnt reloaded from copy, state FETCH. Unsent groups of word_r are discarded (iteration realign).
  - else grp_cnt-1. If grp_idx==WORD_GROUPS-1: state FETCH. Else grp_idx+1.
- SEND with avail_in=0: valid_out<=0, nothing advances. valid_out is never high unless avail_in was 1 at the preceding posedge.
- Downstream receivers hold at least one slot of slack after deasserting avail, so the one-cycle registered lag is legal.
- Latency: word accepted at edge e; earliest valid_out high in cycle after edge e+1.
- Throughput: WORD_GROUPS groups per WORD_GROUPS+1 cycles. FETCH costs one cycle per word with no prefetch.
- done_out is a one-cycle pulse, otherwise 0. valid_out is 0 in every cycle not produced by an emit.
- Counters use plain decrement. Zero counts are trapped only at configure, so counters never wrap.

Test Plan:
1. Reset with configure=1 held and avail_in=1 -> outputs stay 0, word_ready_out=0. Release rst -> state FETCH after the first configure edge.
2. GROUP_SIZE=4, DATA_WIDTH=8, WORD_GROUPS=4, num_iters=1, groups=8; words 0x44332211_..., avail_in=1 constantly -> 8 valid_out pulses with group order 0..3 per word, two word handshakes, done_out coincides with the 8th pulse.
3. num_iters=3, groups=6, avail_in=1 -> per iteration 4+2 groups. Groups 2,3 of each iteration's second word never appear. 6 word handshakes, 18 pulses, one done.
4. Same as 2 with avail_in toggling 1,0,1,0 -> valid_out high only in cycles following an avail_in=1 edge; output sequence identical to scenario 2.
5. configure mid-SEND (after 3 groups of groups=8) with new groups=2 -> valid_out 0 next cycle, old word dropped, fresh fetch, exactly 2 further pulses then done.
6. configure with num_iters=0 -> no word_ready_out, done_out pulses once in the next cycle, state IDLE.

Source files
------------

// File: rtl/group_tx.sv
// Transmit end of the group stream: accepts wide words from a ready/valid source and
// emits them one GROUP_SIZE-item group per cycle on data/valid/avail, for num_iters iterations.
module group_tx #(
  parameter int GROUP_SIZE              = 4,
  parameter int DATA_WIDTH              = 8,
  parameter int WORD_GROUPS             = 4,
  parameter int LOG_WORD_GROUPS         = 2,
  parameter int LOG_MAX_ITERS           = 16,
  parameter int LOG_MAX_GROUPS_PER_ITER = 16
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             configure,
  input  logic [LOG_MAX_ITERS-1:0]                         num_iters,
  input  logic [LOG_MAX_GROUPS_PER_ITER-1:0]               num_groups_per_iter,
  input  logic [WORD_GROUPS*GROUP_SIZE*DATA_WIDTH-1:0]     word_in,
  input  logic                                             word_valid_in,
  output logic                                             word_ready_out,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0]                 data_out,
  output logic                                             valid_out,
  input  logic                                             avail_in,
  output logic                                             done_out
);

  localparam int GW = GROUP_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t                               r_state, w_state;
  logic [LOG_MAX_ITERS-1:0]             r_iter_cnt, w_iter_cnt;
  logic [LOG_MAX_GROUPS_PER_ITER-1:0]   r_grp_cnt, w_grp_cnt;
  logic [LOG_MAX_GROUPS_PER_ITER-1:0]   r_grp_reload, w_grp_reload;
  logic [LOG_WORD_GROUPS-1:0]           r_grp_idx, w_grp_idx;
  logic [WORD_GROUPS-1:0][GW-1:0]       r_word, w_word;
  logic [GW-1:0]                        r_data, w_data;
  logic                                 r_valid, w_valid;
  logic                                 r_done, w_done;
  logic                                 w_last_grp, w_last_iter, w_last_in_word;

  assign w_last_grp     = (r_grp_cnt == LOG_MAX_GROUPS_PER_ITER'(1));
  assign w_last_iter    = (r_iter_cnt == LOG_MAX_ITERS'(1));
  assign w_last_in_word = (r_grp_idx == LOG_WORD_GROUPS'(WORD_GROUPS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_iter_cnt   <= '0;
      r_grp_cnt    <= '0;
      r_grp_reload <= '0;
      r_grp_idx    <= '0;
      r_word       <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_iter_cnt   <= w_iter_cnt;
      r_grp_cnt    <= w_grp_cnt;
      r_grp_reload <= w_grp_reload;
      r_grp_idx    <= w_grp_idx;
      r_word       <= w_word;
      r_data       <= w_data;
      r_valid      <= w_valid;
      r_done       <= w_done;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_iter_cnt   = r_iter_cnt;
    w_grp_cnt    = r_grp_cnt;
    w_grp_reload = r_grp_reload;
    w_grp_idx    = r_grp_idx;
    w_word       = r_word;
    w_data       = r_data;
    w_valid      = 1'b0;
    w_done       = 1'b0;

    if (configure) begin
      w_iter_cnt   = num_iters;
      w_grp_cnt    = num_groups_per_iter;
      w_grp_reload = num_groups_per_iter;
      w_grp_idx    = '0;
      // Zero counts are trapped here so the decrements below can never wrap.
      if (num_iters == '0 || num_groups_per_iter == '0) begin
        w_state = IDLE;
        w_done  = 1'b1;
      end else begin
        w_state = FETCH;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (word_valid_in) begin
            w_word    = word_in;
            w_grp_idx = '0;
            w_state   = SEND;
          end
        end
        SEND: begin
          if (avail_in) begin
            w_data  = r_word[r_grp_idx];
            w_valid = 1'b1;
            if (w_last_grp && w_last_iter) begin
              w_state = IDLE;
              w_done  = 1'b1;
            end else if (w_last_grp) begin
              // Next iteration restarts at group 0 of a fresh word.
              w_iter_cnt = r_iter_cnt - LOG_MAX_ITERS'(1);
              w_grp_cnt  = r_grp_reload;
              w_state    = FETCH;
            end else begin
              w_grp_cnt = r_grp_cnt - LOG_MAX_GROUPS_PER_ITER'(1);
              if (w_last_in_word) begin
                w_state = FETCH;
              end else begin
                w_grp_idx = r_grp_idx + LOG_WORD_GROUPS'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign word_ready_out = (r_state == FETCH);
  assign data_out       = r_data;
  assign valid_out      = r_valid;
  assign done_out       = r_done;

endmodule
